// File: rtl/booth_pp_accumulator.sv
// rtl/booth_pp_accumulator.sv - serial accumulator summing Booth partial products one term per clock
module booth_pp_accumulator #(
  parameter int DATA_WIDTH       = 32,
  parameter int DATA_WIDTH_TERMS = DATA_WIDTH * 2,
  parameter int NUM_TERMS        = 12,
  parameter int CAPACITY_RESULT  = DATA_WIDTH_TERMS * NUM_TERMS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CAPACITY_RESULT-1:0]  partial_products,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH_TERMS-1:0] product,
  output logic                        busy
);

  // A single term still needs one index bit so the register is never zero-width.
  localparam int IDX_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CAPACITY_RESULT-1:0]  pp_q, pp_d;
  logic [DATA_WIDTH_TERMS-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DATA_WIDTH_TERMS-1:0] term_sel;
  logic                        accept;

  // Ready when idle, or when the held result is being consumed this very cycle.
  assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Outputs come straight from registered state; nothing from in_valid reaches them.
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM);
  assign product   = acc_q;

  // Pick the captured term addressed by the running index.
  always_comb begin
    term_sel = pp_q[int'(idx_q) * DATA_WIDTH_TERMS +: DATA_WIDTH_TERMS];
  end

  // Next-state: capture a bus, add one term per cycle, then hold the sum until taken.
  always_comb begin
    state_d = state_q;
    pp_d    = pp_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pp_d    = partial_products;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Plain modular add: wrap is the intended two's-complement behaviour.
        acc_d = acc_q + term_sel;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            // Back-to-back: the next bus is captured on the same edge the result leaves.
            pp_d    = partial_products;
            acc_d   = '0;
            idx_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pp_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pp_q    <= pp_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

endmodule
